// File: rtl/global_pool_stat_if.sv
// rtl/global_pool_stat_if.sv - start/busy/result handshake and feature-memory read port of global_pool_stat
interface global_pool_stat_if #(
  parameter int LOG2_N = 10
);
  logic              ready;
  logic              busy;
  logic              crd;
  logic              csel;
  logic [11:0]       caddr_rd;
  logic [12:0]       cdata_rd;
  logic [12:0]       gmax;
  logic [LOG2_N-1:0] gmax_addr;
  logic [12:0]       gavg;
  logic              valid;

  modport slave (
    input  ready, cdata_rd,
    output busy, crd, csel, caddr_rd, gmax, gmax_addr, gavg, valid
  );

  modport master (
    output ready, cdata_rd,
    input  busy, crd, csel, caddr_rd, gmax, gmax_addr, gavg, valid
  );
endinterface

// File: rtl/global_pool_stat.sv
// rtl/global_pool_stat.sv - scans N_WORDS layer-1 feature words and reports global max, its address and the rounded mean
module global_pool_stat #(
  parameter int N_WORDS = 1024,
  parameter int LOG2_N  = 10
) (
  input  logic              clk,
  input  logic              reset,
  global_pool_stat_if.slave bus
);
  localparam int ACC_W = LOG2_N + 14;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_q;
  logic              busy_q, crd_q, valid_q, rd_pend_q;
  logic [LOG2_N-1:0] addr_q, rd_addr_q, max_addr_q, gmax_addr_q;
  logic [ACC_W-1:0]  acc_q;
  logic [12:0]       max_q, gmax_q, gavg_q;

  logic [ACC_W-1:0]  acc_d, rnd_sum;
  logic [12:0]       max_d, gavg_d;
  logic [LOG2_N-1:0] max_addr_d;

  // Running sum/max including the word arriving this cycle; only trusted when a read was issued last cycle.
  always_comb begin
    acc_d      = acc_q;
    max_d      = max_q;
    max_addr_d = max_addr_q;
    if (rd_pend_q) begin
      acc_d = acc_q + ACC_W'(bus.cdata_rd);
      if ((rd_addr_q == '0) || (bus.cdata_rd > max_q)) begin
        max_d      = bus.cdata_rd;
        max_addr_d = rd_addr_q;
      end
    end
  end

  assign rnd_sum = acc_d + ACC_W'(N_WORDS / 2);
  assign gavg_d  = 13'(rnd_sum >> LOG2_N);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      crd_q       <= 1'b0;
      valid_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      addr_q      <= '0;
      rd_addr_q   <= '0;
      max_addr_q  <= '0;
      gmax_addr_q <= '0;
      acc_q       <= '0;
      max_q       <= '0;
      gmax_q      <= '0;
      gavg_q      <= '0;
    end else begin
      acc_q      <= acc_d;
      max_q      <= max_d;
      max_addr_q <= max_addr_d;
      rd_pend_q  <= crd_q;
      rd_addr_q  <= addr_q;
      valid_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ready) begin
            state_q    <= READ;
            busy_q     <= 1'b1;
            crd_q      <= 1'b1;
            addr_q     <= '0;
            acc_q      <= '0;
            max_q      <= '0;
            max_addr_q <= '0;
          end
        end
        READ: begin
          if (addr_q == LOG2_N'(N_WORDS - 1)) begin
            state_q <= DRAIN;
            crd_q   <= 1'b0;
          end else begin
            addr_q <= addr_q + LOG2_N'(1);
          end
        end
        DRAIN: begin
          // Last word lands now, so results are taken from the combinational next-state values.
          state_q     <= DONE;
          valid_q     <= 1'b1;
          gmax_q      <= max_d;
          gmax_addr_q <= max_addr_d;
          gavg_q      <= gavg_d;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.crd       = crd_q;
  assign bus.csel      = 1'b1;
  assign bus.caddr_rd  = 12'(addr_q);
  assign bus.gmax      = gmax_q;
  assign bus.gmax_addr = gmax_addr_q;
  assign bus.gavg      = gavg_q;
  assign bus.valid     = valid_q;
endmodule

// File: tb/tb_global_pool_stat.sv
// tb/tb_global_pool_stat.sv - directed scans with a result scoreboard and a protocol/hold monitor
module tb_global_pool_stat;
  localparam int N  = 1024;
  localparam int LG = 10;

  typedef struct packed {
    logic [12:0]   gmax;
    logic [LG-1:0] addr;
    logic [12:0]   gavg;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  global_pool_stat_if #(.LOG2_N(LG)) bus ();
  global_pool_stat #(.N_WORDS(N), .LOG2_N(LG)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [12:0] mem [N];
  exp_t        exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  // Unread cycles return all-ones so a design that samples them corrupts max/sum.
  always @(posedge clk) bus.cdata_rd <= bus.crd ? mem[bus.caddr_rd[LG-1:0]] : 13'h1fff;

  function automatic void chk(string name, longint act, longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  int            busy_len = 0, crd_len = 0, exp_addr = 0;
  logic          busy_prev = 1'b0;
  logic [12:0]   h_gmax = '0, h_gavg = '0;
  logic [LG-1:0] h_addr = '0;
  exp_t          e;

  always @(negedge clk) begin
    if (!reset) begin
      busy_len = 0; crd_len = 0; exp_addr = 0; busy_prev = 1'b0;
      h_gmax = '0; h_gavg = '0; h_addr = '0;
    end else begin
      if (bus.crd) begin
        chk("caddr_step", bus.caddr_rd, exp_addr);
        exp_addr++;
        crd_len++;
      end
      if (bus.busy) busy_len++;
      if (busy_prev && !bus.busy) begin
        chk("busy_len", busy_len, N + 2);
        chk("crd_len", crd_len, N);
        busy_len = 0; crd_len = 0; exp_addr = 0;
      end
      if (bus.valid) begin
        chk("valid_with_busy", bus.busy, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("gmax", bus.gmax, e.gmax);
          chk("gmax_addr", bus.gmax_addr, e.addr);
          chk("gavg", bus.gavg, e.gavg);
        end
        h_gmax = bus.gmax; h_addr = bus.gmax_addr; h_gavg = bus.gavg;
      end else begin
        chk("results_hold", {bus.gmax, bus.gmax_addr, bus.gavg}, {h_gmax, h_addr, h_gavg});
      end
      busy_prev = bus.busy;
    end
  end

  task automatic push_exp(int g, int a, int v);
    exp_t x;
    x.gmax = 13'(g); x.addr = LG'(a); x.gavg = 13'(v);
    exp_q.push_back(x);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (bus.busy && cyc < 3000) begin
      @(posedge clk); #2;
      cyc++;
    end
    if (cyc >= 3000) chk("scan_timeout", 1, 0);
  endtask

  task automatic run_scan();
    @(posedge clk); #2 bus.ready = 1'b1;
    @(posedge clk); #2 bus.ready = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_crd"}, bus.crd, 0);
    chk({tag, "_valid"}, bus.valid, 0);
    chk({tag, "_caddr"}, bus.caddr_rd, 0);
    chk({tag, "_gmax"}, bus.gmax, 0);
    chk({tag, "_gmax_addr"}, bus.gmax_addr, 0);
    chk({tag, "_gavg"}, bus.gavg, 0);
    chk({tag, "_csel"}, bus.csel, 1);
  endtask

  initial begin
    int cyc;
    int gap;
    bus.ready = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    #1 reset = 1'b1;

    // all zero
    push_exp(0, 0, 0);
    run_scan();

    // ramp: sum 523776
    for (int i = 0; i < N; i++) mem[i] = 13'(i);
    push_exp(1023, 1023, 512);
    run_scan();

    // saturated words, tie keeps address 0
    for (int i = 0; i < N; i++) mem[i] = 13'h1fff;
    push_exp(8191, 0, 8191);
    run_scan();

    // two equal peaks, lowest address wins
    for (int i = 0; i < N; i++) mem[i] = '0;
    mem[5] = 13'd100; mem[900] = 13'd100;
    push_exp(100, 5, 0);
    run_scan();

    // reset mid-scan aborts without valid, then a clean rescan
    for (int i = 0; i < N; i++) mem[i] = 13'(i);
    @(posedge clk); #2 bus.ready = 1'b1;
    @(posedge clk); #2 bus.ready = 1'b0;
    repeat (500) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("abort");
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("abort_stays_idle", bus.busy, 0);
    push_exp(1023, 1023, 512);
    run_scan();

    // ready held across two scans: i mod 256 then descending ramp
    for (int i = 0; i < N; i++) mem[i] = 13'(i % 256);
    push_exp(255, 255, 128);
    push_exp(1023, 0, 512);
    @(posedge clk); #2 bus.ready = 1'b1;
    cyc = 0;
    while (!bus.valid && cyc < 3000) begin
      @(posedge clk); #2;
      cyc++;
    end
    if (cyc >= 3000) chk("first_done_timeout", 1, 0);
    for (int i = 0; i < N; i++) mem[i] = 13'(1023 - i);
    wait_idle();
    gap = 0;
    while (!bus.busy && gap < 10) begin
      gap++;
      @(posedge clk); #2;
    end
    chk("idle_gap", gap, 1);
    bus.ready = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #2 chk("pending_expect", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/global_pool_stat.md
GLOBAL_POOL_STAT -- requirements
Module: global_pool_stat

Interface
REQ-001 The block SHALL have parameter N_WORDS, default 1024, meaning the number of layer-1 feature-map words scanned (power of two).
REQ-002 The block SHALL have parameter LOG2_N, default 10, meaning log2(N_WORDS).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port ready, input, 1 bit, meaning a start request.
REQ-006 The block SHALL have port busy, output, 1 bit, meaning a scan is in progress.
REQ-007 The block SHALL have port crd, output, 1 bit, meaning feature-memory read enable.
REQ-008 The block SHALL have port csel, output, 1 bit, meaning memory select; it is tied to 1 (layer-1 memory).
REQ-009 The block SHALL have port caddr_rd, output, 12 bits, meaning the read address; bits above LOG2_N are 0.
REQ-010 The block SHALL have port cdata_rd, input, 13 bits, meaning unsigned read data (9.4 fixed point).
REQ-011 The block SHALL have port gmax, output, 13 bits, meaning the global maximum value.
REQ-012 The block SHALL have port gmax_addr, output, LOG2_N bits, meaning the address of gmax.
REQ-013 The block SHALL have port gavg, output, 13 bits, meaning the rounded global average.
REQ-014 The block SHALL have port valid, output, 1 bit, a one-cycle pulse marking results updated.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, READ, DRAIN and DONE.
REQ-016 In IDLE with ready=1 at a rising edge, the block SHALL enter READ, set busy=1, and clear the accumulator, running max and address counter.
REQ-017 ready SHALL be ignored while busy=1.
REQ-018 In READ, crd SHALL be 1 and caddr_rd SHALL equal the counter k = 0..N_WORDS-1, incrementing by 1 per cycle.
REQ-019 Memory read latency is one cycle: data for the address driven in cycle k SHALL be sampled from cdata_rd at the rising edge ending cycle k+1.
REQ-020 cdata_rd SHALL be ignored in any cycle where no read was issued in the prior cycle, since it may be X.
REQ-021 After address N_WORDS-1 is issued, the block SHALL go to DRAIN for one cycle with crd=0 and capture the last word.
REQ-022 In DRAIN, caddr_rd SHALL hold its last value.
REQ-023 The accumulator SHALL be LOG2_N+13+1 bits (24 at default) and unsigned, so it never overflows.
REQ-024 The max update SHALL use strict greater-than, so on a tie the lowest address is kept.
REQ-025 The running max SHALL initialise from word 0, so gmax_addr is 0 when all words are equal.
REQ-026 In DONE, which lasts one cycle, gavg SHALL be loaded with (sum + N_WORDS/2) >> LOG2_N.
REQ-027 In DONE, gmax and gmax_addr SHALL be loaded from the running max.
REQ-028 In DONE, valid SHALL be 1; busy SHALL stay 1 during DONE and fall at the following edge, when the FSM returns to IDLE.
REQ-029 busy SHALL be high for exactly N_WORDS+2 cycles per scan (1026 at default).
REQ-030 gmax, gmax_addr and gavg SHALL hold stable from DONE until the next DONE, including during a subsequent scan.
REQ-031 If ready is still 1 on return to IDLE, a new scan SHALL start at the next edge, giving one idle cycle between scans.
REQ-032 crd SHALL be 0 in IDLE, DRAIN and DONE.

Reset
REQ-033 On reset=0, independent of clk, the FSM SHALL go to IDLE.
REQ-034 On reset=0, busy, crd, valid, caddr_rd, gmax, gmax_addr, gavg, accumulator, running max and counter SHALL all be 0; csel SHALL be 1.
REQ-035 A reset asserted mid-scan SHALL abort the scan without asserting valid.
REQ-036 After reset deasserts, the block SHALL await a fresh ready.

Verification
REQ-037 All words 0, ready pulse -> busy high for 1026 cycles; valid pulse; gmax=0, gmax_addr=0, gavg=0.
REQ-038 mem[i]=i -> gmax=1023, gmax_addr=1023, gavg=512 (sum 523776, +512, >>10).
REQ-039 All words 8191 -> gmax=8191, gmax_addr=0, gavg=8191 (no overflow).
REQ-040 mem[5]=mem[900]=100, others 0 -> gmax=100, gmax_addr=5, gavg=0; also check that caddr_rd steps 0..1023 with crd high for exactly 1024 cycles.
REQ-041 reset=0 at cycle 500 of a scan -> all outputs 0 immediately, no valid pulse; a following ready produces correct results.
REQ-042 ready held high across two scans with different data -> the second scan starts one cycle after busy falls; results from the first scan hold until the second DONE.
